// File: rtl/kw_arb_rr_hold.sv
// Round-robin arbiter that holds each grant until the holder signals done or drops its request.
// Optional forced release after MAX_HOLD cycles: define KW_ARB_RR_TIMEOUT_EN.

module kw_onehot_dec #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [IDX_WIDTH-1:0] idx_i,
    input  logic                 valid_i,
    output logic [N-1:0]         onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < N; k++) begin
            if (valid_i && (idx_i == IDX_WIDTH'(k))) begin
                onehot_o[k] = 1'b1;
            end
        end
    end

endmodule

module kw_arb_rr_hold #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = (N > 1) ? $clog2(N) : 1,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         i_req,
    input  logic                 i_done,
    output logic                 o_gnt_v,
    output logic [IDX_WIDTH-1:0] o_gnt_idx,
    output logic [N-1:0]         o_gnt,
    output logic                 o_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   ptr_q;
    logic [IDX_WIDTH-1:0]   ptr_d;
    logic [IDX_WIDTH-1:0]   gntIdx_q;
    logic                   gntV_q;

    logic                   holderReq;
    logic                   normalRelease;
    logic                   forcedRelease;
    logic                   releaseNow;
    logic                   newGrant;
    logic [IDX_WIDTH-1:0]   pickBase;
    logic [2*N-1:0]         reqDbl;
    logic [N-1:0]           reqRot;
    logic [IDX_WIDTH:0]     pickSum;
    logic [IDX_WIDTH-1:0]   pickIdx;
    logic                   pickFound;

    if (N < 1 || MAX_HOLD < 2) begin : g_param_check
        $error("kw_arb_rr_hold: N must be >= 1 and MAX_HOLD must be >= 2");
    end

    always_comb begin
        holderReq = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (gntIdx_q == IDX_WIDTH'(k)) begin
                holderReq = i_req[k];
            end
        end
    end

    assign normalRelease = (state_q == HOLD) && (i_done || !holderReq);
    assign releaseNow    = normalRelease || forcedRelease;
    assign ptr_d         = (gntIdx_q == IDX_WIDTH'(N - 1)) ? '0 : gntIdx_q + 1'b1;

    // In a release cycle the search already starts from the post-release pointer,
    // which is what lets the next holder be granted without an idle bubble.
    assign pickBase = (state_q == HOLD) ? ptr_d : ptr_q;
    assign reqDbl   = {i_req, i_req} >> pickBase;
    assign reqRot   = reqDbl[N-1:0];

    always_comb begin
        pickFound = 1'b0;
        pickSum   = '0;
        pickIdx   = '0;
        for (int j = 0; j < N; j++) begin
            if (!pickFound && reqRot[j]) begin
                pickFound = 1'b1;
                pickSum   = {1'b0, pickBase} + (IDX_WIDTH + 1)'(j);
            end
        end
        if (pickSum >= (IDX_WIDTH + 1)'(N)) begin
            pickIdx = IDX_WIDTH'(pickSum - (IDX_WIDTH + 1)'(N));
        end else begin
            pickIdx = IDX_WIDTH'(pickSum);
        end
    end

    assign newGrant = pickFound && ((state_q == IDLE) || releaseNow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gntIdx_q <= '0;
            gntV_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        gntIdx_q <= pickIdx;
                        gntV_q   <= 1'b1;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (releaseNow) begin
                        ptr_q <= ptr_d;
                        if (pickFound) begin
                            gntIdx_q <= pickIdx;
                        end else begin
                            gntV_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gntV_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef KW_ARB_RR_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] holdCnt_q;
    logic             timeout_q;

    assign forcedRelease = (state_q == HOLD) && !normalRelease
                           && (holdCnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= forcedRelease;
            if (newGrant || releaseNow) begin
                holdCnt_q <= '0;
            end else if (state_q == HOLD) begin
                holdCnt_q <= holdCnt_q + 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unusedNewGrant;

    assign forcedRelease  = 1'b0;
    assign unusedNewGrant = newGrant;
    assign o_timeout      = 1'b0;
`endif

    assign o_gnt_v   = gntV_q;
    assign o_gnt_idx = gntIdx_q;

    kw_onehot_dec #(
        .N         (N),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_dec (
        .idx_i    (gntIdx_q),
        .valid_i  (gntV_q),
        .onehot_o (o_gnt)
    );

endmodule

// File: tb/tb_kw_arb_rr_hold.sv
// Scoreboard bench for kw_arb_rr_hold: a 4-requester and a 3-requester instance share clock and reset.
// Timeout expectations follow KW_ARB_RR_TIMEOUT_EN when it is defined for the build.

module tb_kw_arb_rr_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       gntV;
    logic [1:0] gntIdx;
    logic [3:0] gnt;
    logic       timeout;

    logic [2:0] req3;
    logic       done3;
    logic       gntV3;
    logic [1:0] gntIdx3;
    logic [2:0] gnt3;
    logic       timeout3;

    typedef struct packed {
        logic       v;
        logic [1:0] idx;
        logic [3:0] gnt;
        logic       to;
    } obs_t;

    typedef struct {
        string name;
        obs_t  exp;
        bit    chkIdx;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    kw_arb_rr_hold #(.N(4), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_gnt_v   (gntV),
        .o_gnt_idx (gntIdx),
        .o_gnt     (gnt),
        .o_timeout (timeout)
    );

    kw_arb_rr_hold #(.N(3), .MAX_HOLD(4)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req3),
        .i_done    (done3),
        .o_gnt_v   (gntV3),
        .o_gnt_idx (gntIdx3),
        .o_gnt     (gnt3),
        .o_timeout (timeout3)
    );

    function automatic obs_t makeExp(logic v, logic [1:0] idx, logic to);
        obs_t e;
        e.v   = v;
        e.idx = v ? idx : 2'd0;
        e.gnt = v ? (4'b0001 << idx) : 4'b0000;
        e.to  = to;
        return e;
    endfunction

    task automatic checkOutput(string name, obs_t act, obs_t exp, bit chkIdx);
        assertCount++;
        if (act.v !== exp.v || act.gnt !== exp.gnt || act.to !== exp.to
            || (chkIdx && act.idx !== exp.idx)) begin
            failCount++;
            $display("[TB] FAIL %s: got v=%0b idx=%0d gnt=%b to=%0b, expected v=%0b idx=%0d gnt=%b to=%0b",
                     name, act.v, act.idx, act.gnt, act.to, exp.v, exp.idx, exp.gnt, exp.to);
        end
    endtask

    // Drives one cycle of inputs; the expectation is for outputs after the next rising edge.
    task automatic applyStimulus(string name, logic [3:0] r, logic d,
                                 logic v, logic [1:0] idx, logic to);
        exp_t e;
        req  = r;
        done = d;
        @(posedge clk);
        e.name   = name;
        e.exp    = makeExp(v, idx, to);
        e.chkIdx = v;
        q4.push_back(e);
        @(negedge clk);
    endtask

    task automatic applyStimulus3(string name, logic [2:0] r, logic d,
                                  logic v, logic [1:0] idx);
        exp_t e;
        req3  = r;
        done3 = d;
        @(posedge clk);
        e.name   = name;
        e.exp    = makeExp(v, idx, 1'b0);
        e.chkIdx = v;
        q3.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkReset(string name);
        checkOutput({name, "_n4"}, {gntV, gntIdx, gnt, timeout}, makeExp(1'b0, 2'd0, 1'b0), 1'b1);
        checkOutput({name, "_n3"}, {gntV3, gntIdx3, 1'b0, gnt3, timeout3}, makeExp(1'b0, 2'd0, 1'b0), 1'b1);
    endtask

    // Monitors pop one expectation per cycle, sampling on the falling edge.
    always @(negedge clk) begin : mon4
        exp_t e;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput(e.name, {gntV, gntIdx, gnt, timeout}, e.exp, e.chkIdx);
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (q3.size() > 0) begin
            e = q3.pop_front();
            checkOutput(e.name, {gntV3, gntIdx3, 1'b0, gnt3, timeout3}, e.exp, e.chkIdx);
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        req3  = 3'b000;
        done3 = 1'b0;
        #2;
        checkReset("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Alternating holders 1 and 3, done every third hold cycle.
        applyStimulus("t1_grant1",   4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("t1_hold1a",   4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("t1_hold1b",   4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("t1_grant3",   4'b1010, 1'b1, 1'b1, 2'd3, 1'b0);
        applyStimulus("t1_hold3a",   4'b1010, 1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus("t1_hold3b",   4'b1010, 1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus("t1_regrant1", 4'b1010, 1'b1, 1'b1, 2'd1, 1'b0);
        applyStimulus("t1_hold1c",   4'b1010, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("t1_idle",     4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        #2 rst_n = 1'b0;
        #1 checkReset("reset_t2");
        @(negedge clk);
        rst_n = 1'b1;

        // Full rotation with wrap 3 -> 0.
        applyStimulus("t2_idx0",  4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        applyStimulus("t2_idx1",  4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);
        applyStimulus("t2_idx2",  4'b1111, 1'b1, 1'b1, 2'd2, 1'b0);
        applyStimulus("t2_idx3",  4'b1111, 1'b1, 1'b1, 2'd3, 1'b0);
        applyStimulus("t2_wrap0", 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        applyStimulus("t2_idx1b", 4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);

        // Holder 2 drops its request; ptr moves to 3 so requester 0 wins after wrap.
        applyStimulus("t3_grant2",   4'b1111, 1'b1, 1'b1, 2'd2, 1'b0);
        applyStimulus("t3_drop2",    4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("t3_idle",     4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus("t3_ptr3",     4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus("t3_idle2",    4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Asynchronous reset between edges while holding.
        applyStimulus("t5_grant1",   4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus("t5_hold1",    4'b0110, 1'b0, 1'b1, 2'd1, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkReset("t5_midhold_reset");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("t5_grant3",   4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus("t5_idle",     4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        // Non-power-of-two rotation on the 3-requester instance.
        applyStimulus3("t4_idx0",  3'b111, 1'b1, 1'b1, 2'd0);
        applyStimulus3("t4_idx1",  3'b111, 1'b1, 1'b1, 2'd1);
        applyStimulus3("t4_idx2",  3'b111, 1'b1, 1'b1, 2'd2);
        applyStimulus3("t4_wrap0", 3'b111, 1'b1, 1'b1, 2'd0);
        applyStimulus3("t4_idle",  3'b000, 1'b0, 1'b0, 2'd0);

        // Long hold by requester 0 with requester 1 waiting.
        applyStimulus("t6_grant0", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("t6_hold0a", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("t6_hold0b", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("t6_hold0c", 4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
`ifdef KW_ARB_RR_TIMEOUT_EN
        applyStimulus("t6_forced1", 4'b0011, 1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus("t6_hold1",   4'b0011, 1'b0, 1'b1, 2'd1, 1'b0);
`else
        applyStimulus("t6_hold0d",  4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus("t6_hold0e",  4'b0011, 1'b0, 1'b1, 2'd0, 1'b0);
`endif
        applyStimulus("t6_idle",    4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        assertCount++;
        if (q4.size() != 0 || q3.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d/%0d pending expectations, expected 0/0", q4.size(), q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
